sdram_bram_model: RTL and testbench

SDRAM_BRAM_MODEL -- requirements
Module: sdram_bram_model

---
 rtl/sdram_pkg.sv | 51 +++++
 rtl/sdram_model_mem.sv | 33 +++
 rtl/sdram_bram_model.sv | 208 ++++++++++++++++++++
 tb/tb_sdram_bram_model.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM behavioural model: command encoding,
// burst engine states and mode-register field decoding.
package sdram_pkg;

  // {ras_n, cas_n, we_n}
  typedef enum logic [2:0] {
    CMD_LOAD_MODE  = 3'b000,
    CMD_REFRESH    = 3'b001,
    CMD_PRECHARGE  = 3'b010,
    CMD_ACTIVE     = 3'b011,
    CMD_WRITE      = 3'b100,
    CMD_READ       = 3'b101,
    CMD_BURST_TERM = 3'b110,
    CMD_NOP        = 3'b111
  } sdram_cmd_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_READ,
    B_WRITE
  } burst_state_e;

  localparam int MR_BL_LSB = 0;
  localparam int MR_BL_MSB = 2;
  localparam int MR_CL_LSB = 4;
  localparam int MR_CL_MSB = 6;

  typedef struct packed {
    logic [3:0] value;
    logic       err;
  } mode_field_t;

  function automatic mode_field_t decode_bl(input logic [2:0] field);
    case (field)
      3'd0:    decode_bl = '{value: 4'd1, err: 1'b0};
      3'd1:    decode_bl = '{value: 4'd2, err: 1'b0};
      3'd2:    decode_bl = '{value: 4'd4, err: 1'b0};
      3'd3:    decode_bl = '{value: 4'd8, err: 1'b0};
      default: decode_bl = '{value: 4'd1, err: 1'b1};
    endcase
  endfunction

  function automatic mode_field_t decode_cl(input logic [2:0] field);
    case (field)
      3'd2:    decode_cl = '{value: 4'd2, err: 1'b0};
      3'd3:    decode_cl = '{value: 4'd3, err: 1'b0};
      default: decode_cl = '{value: 4'd2, err: 1'b1};
    endcase
  endfunction

endpackage

// File: rtl/sdram_model_mem.sv
// Single-port synchronous 16-bit RAM with two byte enables and a
// registered read port (one cycle of read latency).
module sdram_model_mem #(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [1:0]           be_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [15:0]          wdata_i,
  output logic [15:0]          rdata_o
);

  logic [15:0] mem_q [2**ADDR_BITS];
  logic [15:0] rdata_q;

  // NOTE: the storage array has no reset; clearing it would need a
  // per-word write port and would also erase data that must survive rst.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_bram_model.sv
// Cycle-level SDRAM device model backed by on-chip RAM. Protocol checking
// is compiled in only when SDRAM_MODEL_CHECK_EN is defined.
module sdram_bram_model
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cke,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic [1:0]  sdram_dqm,
  input  logic [12:0] sdram_a,
  input  logic [1:0]  sdram_ba,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic [1:0]  sdram_dq_oe,
  output logic        protocol_err
);

  localparam int ADDR_BITS = 2 + ROW_BITS + COL_BITS;

  sdram_cmd_e   cmd;
  logic         is_rw;
  logic         stop_burst;
  logic         viol;
  mode_field_t  bl_dec;
  mode_field_t  cl_dec;

  logic [3:0]          bl_q;
  logic [3:0]          cl_q;
  logic [3:0]          bank_active_q;
  logic [ROW_BITS-1:0] open_row_q [4];

  burst_state_e        bstate_q;
  logic [2:0]          beat_q;
  logic [1:0]          bbank_q;
  logic [ROW_BITS-1:0] brow_q;
  logic [COL_BITS-1:0] bcol_q;

  logic                 mem_en;
  logic                 mem_we;
  logic [1:0]           mem_be;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [15:0]          mem_rdata;
  logic                 rd_issue;

  logic        p1_valid_q;
  logic        p2_valid_q;
  logic [15:0] p2_data_q;
  logic [1:0]  dqm_q;
  logic        out_valid;
  logic [15:0] out_data;

  // Sequential wrap inside the BL-aligned block; upper column bits held.
  function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] base,
                                                    input logic [2:0] beat,
                                                    input logic [3:0] bl);
    logic [2:0] mask;
    mask      = 3'(bl - 4'd1);
    burst_col = base;
    burst_col[2:0] = (base[2:0] & ~mask) | ((base[2:0] + beat) & mask);
  endfunction

  always_comb begin
    cmd = CMD_NOP;
    if (sdram_cke && !sdram_cs_n && !rst) begin
      cmd = sdram_cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});
    end
  end

  assign is_rw      = (cmd == CMD_READ) || (cmd == CMD_WRITE);
  assign stop_burst = (cmd == CMD_BURST_TERM) ||
                      ((cmd == CMD_PRECHARGE) && (sdram_a[10] || (sdram_ba == bbank_q)));
  assign bl_dec     = decode_bl(sdram_a[MR_BL_MSB:MR_BL_LSB]);
  assign cl_dec     = decode_cl(sdram_a[MR_CL_MSB:MR_CL_LSB]);

  // Beat 0 comes straight from the command pins; later beats from the engine.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_be   = ~sdram_dqm;
    mem_addr = '0;
    rd_issue = 1'b0;
    if (is_rw) begin
      mem_en   = 1'b1;
      mem_we   = (cmd == CMD_WRITE);
      rd_issue = (cmd == CMD_READ);
      mem_addr = {sdram_ba, open_row_q[sdram_ba], sdram_a[COL_BITS-1:0]};
    end else if (!rst && (bstate_q != B_IDLE) && !stop_burst) begin
      mem_en   = 1'b1;
      mem_we   = (bstate_q == B_WRITE);
      rd_issue = (bstate_q == B_READ);
      mem_addr = {bbank_q, brow_q, burst_col(bcol_q, beat_q, bl_q)};
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bl_q          <= 4'd1;
      cl_q          <= 4'd2;
      bank_active_q <= '0;
      for (int i = 0; i < 4; i++) open_row_q[i] <= '0;
    end else begin
      case (cmd)
        CMD_LOAD_MODE: begin
          bl_q <= bl_dec.value;
          cl_q <= cl_dec.value;
        end
        CMD_ACTIVE: begin
          bank_active_q[sdram_ba] <= 1'b1;
          open_row_q[sdram_ba]    <= sdram_a[ROW_BITS-1:0];
        end
        CMD_PRECHARGE: begin
          if (sdram_a[10]) bank_active_q <= '0;
          else             bank_active_q[sdram_ba] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate_q <= B_IDLE;
      beat_q   <= '0;
      bbank_q  <= '0;
      brow_q   <= '0;
      bcol_q   <= '0;
    end else if (is_rw) begin
      beat_q  <= 3'd1;
      bbank_q <= sdram_ba;
      brow_q  <= open_row_q[sdram_ba];
      bcol_q  <= sdram_a[COL_BITS-1:0];
      if (bl_q == 4'd1)             bstate_q <= B_IDLE;
      else if (cmd == CMD_READ)     bstate_q <= B_READ;
      else                          bstate_q <= B_WRITE;
    end else if (bstate_q != B_IDLE) begin
      if (stop_burst || ({1'b0, beat_q} == bl_q - 4'd1)) bstate_q <= B_IDLE;
      else                                              beat_q   <= beat_q + 3'd1;
    end
  end

  sdram_model_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (mem_addr),
    .wdata_i (sdram_dq_in),
    .rdata_o (mem_rdata)
  );

  // CL2 drains from the RAM output register, CL3 from one extra stage.
  always_comb begin
    out_valid = p1_valid_q;
    out_data  = mem_rdata;
    if (cl_q == 4'd3) begin
      out_valid = p2_valid_q;
      out_data  = p2_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_q   <= 1'b0;
      p2_valid_q   <= 1'b0;
      p2_data_q    <= '0;
      dqm_q        <= '0;
      sdram_dq_oe  <= '0;
      sdram_dq_out <= '0;
    end else begin
      p1_valid_q  <= rd_issue;
      p2_valid_q  <= p1_valid_q;
      p2_data_q   <= mem_rdata;
      dqm_q       <= sdram_dqm;
      sdram_dq_oe <= out_valid ? ~dqm_q : 2'b00;
      if (out_valid) sdram_dq_out <= out_data;
    end
  end

  assign viol = (is_rw && !bank_active_q[sdram_ba]) ||
                ((cmd == CMD_ACTIVE) &&
                 (bank_active_q[sdram_ba] || ((sdram_a >> ROW_BITS) != 13'd0))) ||
                ((cmd == CMD_LOAD_MODE) && (bl_dec.err || cl_dec.err));

`ifdef SDRAM_MODEL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (viol) err_q <= 1'b1;
  end

  assign protocol_err = err_q;
`else
  logic unused_viol;
  assign unused_viol  = viol;
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_bram_model.sv
// Scoreboard bench for sdram_bram_model: read beats are queued with their
// due cycle when the READ is driven and compared when the cycle arrives.
module tb_sdram_bram_model;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_BT  = 3'b110;

`ifdef SDRAM_MODEL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sdram_cke;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [1:0]  sdram_dqm;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic [15:0] sdram_dq_in;
  logic [15:0] sdram_dq_out;
  logic [1:0]  sdram_dq_oe;
  logic        protocol_err;

  sdram_bram_model #(.ROW_BITS(4), .COL_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sdram_cke    (sdram_cke),
    .sdram_cs_n   (sdram_cs_n),
    .sdram_ras_n  (sdram_ras_n),
    .sdram_cas_n  (sdram_cas_n),
    .sdram_we_n   (sdram_we_n),
    .sdram_dqm    (sdram_dqm),
    .sdram_a      (sdram_a),
    .sdram_ba     (sdram_ba),
    .sdram_dq_in  (sdram_dq_in),
    .sdram_dq_out (sdram_dq_out),
    .sdram_dq_oe  (sdram_dq_oe),
    .protocol_err (protocol_err)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [1:0]  oe;
    bit          chk_data;
  } exp_t;

  exp_t        sb[$];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en   = 0;
  int          n;
  logic [15:0] wd [8];
  logic [1:0]  wm [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sdram_cke   = 1'b1;
    sdram_cs_n  = 1'b1;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    sdram_dqm   = 2'b00;
    sdram_a     = '0;
    sdram_ba    = '0;
    sdram_dq_in = '0;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a);
    sdram_cs_n = 1'b0;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba   = ba;
    sdram_a    = a;
    tick();
    idle();
  endtask

  task automatic write_burst(input logic [1:0] ba, input logic [7:0] col, input int bl);
    sdram_dq_in = wd[0];
    sdram_dqm   = wm[0];
    cmd(C_WR, ba, {5'b0, col});
    for (int k = 1; k < bl; k++) begin
      sdram_dq_in = wd[k];
      sdram_dqm   = wm[k];
      tick();
    end
    idle();
  endtask

  task automatic read_at(input logic [1:0] ba, input logic [7:0] col, output int issue_cyc);
    issue_cyc = cyc;
    cmd(C_RD, ba, {5'b0, col});
  endtask

  task automatic push(input int c, input logic [15:0] d, input logic [1:0] oe, input bit chk);
    exp_t e;
    e.cyc = c;
    e.data = d;
    e.oe = oe;
    e.chk_data = chk;
    sb.push_back(e);
  endtask

  // Every monitored cycle is either a due read beat or must show oe=0.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("rd_oe", 32'(sdram_dq_oe), 32'(e.oe));
        if (e.chk_data) check("rd_data", 32'(sdram_dq_out), 32'(e.data));
      end else begin
        check("idle_oe", 32'(sdram_dq_oe), 32'd0);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wd[k] = '0;
      wm[k] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;
    check("rst_oe", 32'(sdram_dq_oe), 32'd0);
    check("rst_dq_out", 32'(sdram_dq_out), 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);
    mon_en = 1;

    // CL2 BL1 single write/read
    cmd(C_MRS, 2'd0, 13'h020);
    cmd(C_ACT, 2'd0, 13'd3);
    wd[0] = 16'hBEEF;
    write_burst(2'd0, 8'd5, 1);
    read_at(2'd0, 8'd5, n);
    push(n + 2, 16'hBEEF, 2'b11, 1);
    repeat (4) tick();

    // CL3 BL4 wrapped burst
    cmd(C_MRS, 2'd0, 13'h032);
    for (int k = 0; k < 4; k++) wd[k] = 16'(k + 1);
    write_burst(2'd0, 8'd6, 4);
    read_at(2'd0, 8'd6, n);
    for (int k = 0; k < 4; k++) push(n + 3 + k, 16'(k + 1), 2'b11, 1);
    repeat (7) tick();

    // Column placement of the wrapped burst, read back one word at a time
    cmd(C_MRS, 2'd0, 13'h020);
    read_at(2'd0, 8'd4, n); push(n + 2, 16'd3, 2'b11, 1);
    read_at(2'd0, 8'd5, n); push(n + 2, 16'd4, 2'b11, 1);
    read_at(2'd0, 8'd6, n); push(n + 2, 16'd1, 2'b11, 1);
    read_at(2'd0, 8'd7, n); push(n + 2, 16'd2, 2'b11, 1);
    repeat (4) tick();

    // CL2 BL4 write with low byte masked on beat 1
    cmd(C_MRS, 2'd0, 13'h022);
    wd[0] = 16'hA1A1; wd[1] = 16'hB2B2; wd[2] = 16'hC3C3; wd[3] = 16'hD4D4;
    wm[1] = 2'b01;
    write_burst(2'd0, 8'd4, 4);
    wm[1] = 2'b00;
    read_at(2'd0, 8'd4, n);
    push(n + 2, 16'hA1A1, 2'b11, 1);
    push(n + 3, 16'hB204, 2'b11, 1);
    push(n + 4, 16'hC3C3, 2'b11, 1);
    push(n + 5, 16'hD4D4, 2'b11, 1);
    repeat (5) tick();

    // Read-side dqm: high byte masked one cycle after the READ
    read_at(2'd0, 8'd4, n);
    push(n + 2, 16'hA1A1, 2'b11, 1);
    push(n + 3, 16'hB204, 2'b01, 1);
    push(n + 4, 16'hC3C3, 2'b11, 1);
    push(n + 5, 16'hD4D4, 2'b11, 1);
    sdram_dqm = 2'b10;
    tick();
    sdram_dqm = 2'b00;
    repeat (6) tick();

    // BL8 read cut short by BURST_TERM two cycles after the READ
    cmd(C_MRS, 2'd0, 13'h023);
    for (int k = 0; k < 8; k++) wd[k] = 16'h1000 + 16'(k);
    write_burst(2'd0, 8'h10, 8);
    read_at(2'd0, 8'h10, n);
    push(n + 2, 16'h1000, 2'b11, 1);
    push(n + 3, 16'h1001, 2'b11, 1);
    tick();
    cmd(C_BT, 2'd0, 13'd0);
    repeat (10) tick();
    check("dq_hold", 32'(sdram_dq_out), 32'h1001);

    // READ to unopened bank 2
    cmd(C_MRS, 2'd0, 13'h020);
    read_at(2'd2, 8'd0, n);
    push(n + 2, 16'h0000, 2'b11, 0);
    check("proto_err_set", 32'(protocol_err), 32'(EXP_ERR));
    repeat (5) tick();
    check("proto_err_sticky", 32'(protocol_err), 32'(EXP_ERR));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("proto_err_clr", 32'(protocol_err), 32'd0);

    // Reset in the middle of a BL8 read; memory survives
    cmd(C_MRS, 2'd0, 13'h023);
    cmd(C_ACT, 2'd0, 13'd3);
    read_at(2'd0, 8'h10, n);
    push(n + 2, 16'h1000, 2'b11, 1);
    push(n + 3, 16'h1001, 2'b11, 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_oe", 32'(sdram_dq_oe), 32'd0);
    check("midrst_dq_out", 32'(sdram_dq_out), 32'd0);
    repeat (3) tick();
    cmd(C_ACT, 2'd0, 13'd3);
    read_at(2'd0, 8'h12, n);
    push(n + 2, 16'h1002, 2'b11, 1);
    repeat (5) tick();

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
